// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back write-allocate data cache, one word per line
module dcache_wb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_REFILL_REQ,
    S_REFILL_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] init_cnt_q, init_cnt_d;
  logic               req_we_q, req_we_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_W-1:0] req_idx_q, req_idx_d;
  logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;

  logic               valid_q [LINES];
  logic               dirty_q [LINES];
  logic [TAG_W-1:0]   tag_q   [LINES];
  logic [DATA_W-1:0]  data_q  [LINES];

  // Single write port into the line arrays, shared by sweep, store hit, writeback and refill
  logic [INDEX_W-1:0] wr_idx;
  logic               valid_we, valid_wd;
  logic               dirty_we, dirty_wd;
  logic               tag_we;
  logic               data_we;
  logic [DATA_W-1:0]  data_wd;

  logic               hit;
  logic               unused_addr_bits;

  // Byte offset within the word carries no information for a word-wide cache
  assign unused_addr_bits = &{1'b0, cpu_req_addr[1:0]};

  // Tag compare against the line addressed by the registered request
  assign hit = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);

  // Controller next-state, handshake outputs and array write strobes
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    req_we_d       = req_we_q;
    req_tag_d      = req_tag_q;
    req_idx_d      = req_idx_q;
    req_wdata_d    = req_wdata_q;
    wr_idx         = req_idx_q;
    valid_we       = 1'b0;
    valid_wd       = 1'b0;
    dirty_we       = 1'b0;
    dirty_wd       = 1'b0;
    tag_we         = 1'b0;
    data_we        = 1'b0;
    data_wd        = '0;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;

    case (state_q)
      S_INIT: begin
        wr_idx     = init_cnt_q;
        valid_we   = 1'b1;
        dirty_we   = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          req_we_d    = cpu_req_we;
          req_tag_d   = cpu_req_addr[ADDR_W-1:INDEX_W+2];
          req_idx_d   = cpu_req_addr[INDEX_W+1:2];
          req_wdata_d = cpu_req_wdata;
          state_d     = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          if (req_we_q) begin
            data_we  = 1'b1;
            data_wd  = req_wdata_q;
            dirty_we = 1'b1;
            dirty_wd = 1'b1;
          end else begin
            cpu_resp_rdata = data_q[req_idx_q];
          end
          state_d = S_IDLE;
        end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
          state_d = S_WB;
        end else begin
          state_d = S_REFILL_REQ;
        end
      end
      S_WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_q[req_idx_q], req_idx_q, 2'b00};
        mem_req_wdata = data_q[req_idx_q];
        if (mem_req_ready) begin
          dirty_we = 1'b1;
          state_d  = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag_q, req_idx_q, 2'b00};
        if (mem_req_ready) begin
          state_d = S_REFILL_WAIT;
        end
      end
      S_REFILL_WAIT: begin
        if (mem_resp_valid) begin
          data_we  = 1'b1;
          data_wd  = mem_resp_rdata;
          tag_we   = 1'b1;
          valid_we = 1'b1;
          valid_wd = 1'b1;
          dirty_we = 1'b1;
          state_d  = S_LOOKUP;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Reset wins combinationally so nothing leaks out before the state register settles
    if (reset) begin
      valid_we       = 1'b0;
      dirty_we       = 1'b0;
      tag_we         = 1'b0;
      data_we        = 1'b0;
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = '0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
      mem_req_addr   = '0;
      mem_req_wdata  = '0;
    end
  end

  // Controller and request registers with synchronous reset into the invalidate sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      req_we_q    <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      req_we_q    <= req_we_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // Line arrays; valid/dirty are cleared by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (valid_we) valid_q[wr_idx] <= valid_wd;
    if (dirty_we) dirty_q[wr_idx] <= dirty_wd;
    if (tag_we)   tag_q[wr_idx]   <= req_tag_q;
    if (data_we)  data_q[wr_idx]  <= data_wd;
  end

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - self-checking bench for dcache_wb with reference cache model
module tb_dcache_wb;
  localparam int LINES = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr, cpu_req_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  always #5 clk = ~clk;

  dcache_wb #(.ADDR_W(32), .DATA_W(32), .INDEX_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Memory contents: agent copy is what the DUT sees, ref copy is what the model expects
  logic [31:0] agent_mem [logic [29:0]];
  logic [31:0] ref_mem   [logic [29:0]];

  function automatic logic [31:0] mem_default(input logic [29:0] w);
    logic [31:0] x;
    x = {2'b00, w};
    return (x * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] agent_read(input logic [29:0] w);
    return agent_mem.exists(w) ? agent_mem[w] : mem_default(w);
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_default(w);
  endfunction

  task automatic preset(input logic [31:0] addr, input logic [31:0] val);
    agent_mem[addr[31:2]] = val;
    ref_mem[addr[31:2]]   = val;
  endtask

  // Memory agent state and transaction log
  int          stall_cfg = 0, stall_left = 0, resp_delay = 0;
  bit          resp_pend = 0;
  int          resp_cd = 0;
  logic [31:0] resp_data;
  logic        log_we[$];
  logic [31:0] log_addr[$], log_wdata[$];
  int          log_hold[$];
  int          cur_hold = 0, stab_err = 0;
  bit          prev_wait = 0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;

  // Memory agent: decides ready/response on the falling edge for the next rising edge
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      if (resp_pend) begin
        if (resp_cd == 0) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = resp_data; resp_pend = 0;
        end else resp_cd--;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid === 1'b1) begin
        cur_hold++;
        if (prev_wait && (mem_req_we !== prev_we || mem_req_addr !== prev_addr ||
                          mem_req_wdata !== prev_wdata)) stab_err++;
        if (stall_left == 0) begin
          mem_req_ready = 1'b1;
          log_we.push_back(mem_req_we); log_addr.push_back(mem_req_addr);
          log_wdata.push_back(mem_req_wdata); log_hold.push_back(cur_hold);
          cur_hold = 0; prev_wait = 0; stall_left = stall_cfg;
          if (mem_req_we) agent_mem[mem_req_addr[31:2]] = mem_req_wdata;
          else begin
            resp_pend = 1; resp_cd = resp_delay; resp_data = agent_read(mem_req_addr[31:2]);
          end
        end else begin
          stall_left--; prev_wait = 1;
          prev_we = mem_req_we; prev_addr = mem_req_addr; prev_wdata = mem_req_wdata;
        end
      end else begin
        if (prev_wait && reset !== 1'b1) stab_err++;
        prev_wait = 0; cur_hold = 0;
      end
    end
  end

  // Reference model: abstract direct-mapped write-back write-allocate cache
  bit          m_valid[LINES], m_dirty[LINES];
  logic [25:0] m_tag[LINES];
  logic [31:0] m_data[LINES];
  logic        e_we[$];
  logic [31:0] e_addr[$], e_wdata[$];

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output logic [31:0] rd, output bit hit, output bit wb);
    logic [3:0]  idx;
    logic [25:0] tag;
    idx = addr[5:2]; tag = addr[31:6];
    e_we.delete(); e_addr.delete(); e_wdata.delete();
    hit = m_valid[idx] && (m_tag[idx] == tag);
    wb = 0; rd = '0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        wb = 1;
        e_we.push_back(1'b1); e_addr.push_back({m_tag[idx], idx, 2'b00}); e_wdata.push_back(m_data[idx]);
        ref_mem[{m_tag[idx], idx}] = m_data[idx];
      end
      e_we.push_back(1'b0); e_addr.push_back({addr[31:2], 2'b00}); e_wdata.push_back('0);
      m_data[idx] = ref_read(addr[31:2]); m_tag[idx] = tag; m_valid[idx] = 1; m_dirty[idx] = 0;
    end
    if (we) begin m_data[idx] = wd; m_dirty[idx] = 1; end
    else rd = m_data[idx];
  endtask

  // CPU driver: called and returns on a falling edge; lat counts cycles after acceptance
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat, output logic extra);
    int guard;
    guard = 0;
    log_we.delete(); log_addr.delete(); log_wdata.delete(); log_hold.delete();
    cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wd;
    while (cpu_req_ready !== 1'b1 && guard < 300) begin @(negedge clk); guard++; end
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    lat = 1;
    while (cpu_resp_valid !== 1'b1 && lat < 300) begin @(negedge clk); lat++; end
    rd = cpu_resp_rdata;
    @(negedge clk);
    extra = cpu_resp_valid;
  endtask

  task automatic test_reset();
    int n;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if ({cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_req_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_req_we});
    end
    n_cmp++;
    if ({cpu_resp_rdata, mem_req_addr, mem_req_wdata} !== 96'b0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h want 0", cpu_resp_rdata, mem_req_addr, mem_req_wdata);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_req_we} !== 4'b0 ||
        {cpu_resp_rdata, mem_req_addr, mem_req_wdata} !== 96'b0) begin
      n_fail++; $display("FAIL post_reset_outputs: got ready=%b rv=%b mv=%b mwe=%b want all 0",
                         cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_req_we);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (cpu_req_ready !== 1'b1 && n < 100);
    n_cmp++;
    if (n !== 16) begin n_fail++; $display("FAIL init_sweep_cycles: got %0d want 16", n); end
    model_clear();
  endtask

  task automatic test_cold_load();
    logic [31:0] rd, erd; int lat; logic extra; bit hit, wb;
    stall_cfg = 0; stall_left = 0; resp_delay = 0;
    preset(32'h40, 32'hDEAD_BEEF);
    model_access(1'b0, 32'h40, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h40, '0, rd, lat, extra);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL cold_latency: got %0d want 4", lat); end
    n_cmp++;
    if (log_we.size() !== 1) begin n_fail++; $display("FAIL cold_mem_ops: got %0d ops want 1", log_we.size()); end
    else if (log_we[0] !== 1'b0 || log_addr[0] !== 32'h40) begin
      n_fail++; $display("FAIL cold_mem_op: got we=%b addr=%h want read 00000040", log_we[0], log_addr[0]);
    end
    n_cmp++; if (extra !== 1'b0) begin n_fail++; $display("FAIL cold_pulse_width: got %b want 0", extra); end
    model_access(1'b0, 32'h40, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h40, '0, rd, lat, extra);
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_rdata: got %h want deadbeef", rd); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", lat); end
    n_cmp++; if (log_we.size() !== 0) begin n_fail++; $display("FAIL hit_mem_ops: got %0d want 0", log_we.size()); end
  endtask

  task automatic test_store_hit_wb();
    logic [31:0] rd, erd; int lat; logic extra; bit hit, wb;
    model_access(1'b1, 32'h40, 32'h1234_5678, erd, hit, wb);
    cpu_access(1'b1, 32'h40, 32'h1234_5678, rd, lat, extra);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL store_hit_latency: got %0d want 1", lat); end
    n_cmp++; if (log_we.size() !== 0) begin n_fail++; $display("FAIL store_hit_mem_ops: got %0d want 0", log_we.size()); end
    model_access(1'b0, 32'h440, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h440, '0, rd, lat, extra);
    n_cmp++;
    if (log_we.size() !== 2) begin n_fail++; $display("FAIL evict_mem_ops: got %0d want 2", log_we.size()); end
    else begin
      if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h40 || log_wdata[0] !== 32'h1234_5678) begin
        n_fail++; $display("FAIL evict_writeback: got we=%b addr=%h data=%h want 1 00000040 12345678",
                           log_we[0], log_addr[0], log_wdata[0]);
      end
      n_cmp++;
      if (log_we[1] !== 1'b0 || log_addr[1] !== 32'h440) begin
        n_fail++; $display("FAIL evict_refill: got we=%b addr=%h want 0 00000440", log_we[1], log_addr[1]);
      end
    end
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL evict_rdata: got %h want %h", rd, erd); end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL evict_latency: got %0d want 5", lat); end
  endtask

  task automatic test_store_miss();
    logic [31:0] rd, erd; int lat; logic extra; bit hit, wb;
    preset(32'h80, 32'hAAAA_AAAA);
    model_access(1'b1, 32'h80, 32'h5555_5555, erd, hit, wb);
    cpu_access(1'b1, 32'h80, 32'h5555_5555, rd, lat, extra);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL store_miss_latency: got %0d want 4", lat); end
    n_cmp++;
    if (log_we.size() !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h80) begin
      n_fail++; $display("FAIL store_miss_refill: got %0d ops want one read of 00000080", log_we.size());
    end
    model_access(1'b0, 32'h80, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h80, '0, rd, lat, extra);
    n_cmp++; if (rd !== 32'h5555_5555) begin n_fail++; $display("FAIL merged_rdata: got %h want 55555555", rd); end
    n_cmp++; if (lat !== 1 || log_we.size() !== 0) begin
      n_fail++; $display("FAIL merged_hit: got lat=%0d ops=%0d want 1 0", lat, log_we.size());
    end
    model_access(1'b0, 32'h480, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h480, '0, rd, lat, extra);
    n_cmp++;
    if (log_we.size() < 1 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h80 || log_wdata[0] !== 32'h5555_5555) begin
      n_fail++; $display("FAIL dirty_after_merge: got %0d ops want writeback 00000080=55555555", log_we.size());
    end
  endtask

  task automatic test_wb_stall();
    logic [31:0] rd, erd; int lat; logic extra; bit hit, wb; int st0, nwb;
    stall_cfg = 0; stall_left = 0; resp_delay = 0;
    model_access(1'b1, 32'hC0, 32'hCAFE_F00D, erd, hit, wb);
    cpu_access(1'b1, 32'hC0, 32'hCAFE_F00D, rd, lat, extra);
    stall_cfg = 5; stall_left = 5; st0 = stab_err;
    model_access(1'b0, 32'h4C0, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h4C0, '0, rd, lat, extra);
    nwb = 0;
    foreach (log_we[i]) if (log_we[i] === 1'b1) nwb++;
    n_cmp++; if (nwb !== 1) begin n_fail++; $display("FAIL stall_wb_count: got %0d want 1", nwb); end
    n_cmp++;
    if (log_we.size() < 1 || log_hold[0] !== 6 || log_addr[0] !== 32'hC0 || log_wdata[0] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL stall_wb_hold: got %0d ops, first held %0d want 6 cycles at 000000c0=cafef00d",
                         log_we.size(), (log_hold.size() > 0) ? log_hold[0] : -1);
    end
    n_cmp++; if (stab_err !== st0) begin n_fail++; $display("FAIL stall_stability: got %0d changes want 0", stab_err - st0); end
    n_cmp++; if (lat !== 15) begin n_fail++; $display("FAIL stall_latency: got %0d want 15", lat); end
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL stall_rdata: got %h want %h", rd, erd); end
    stall_cfg = 0; stall_left = 0;
  endtask

  task automatic test_reset_in_refill();
    logic [31:0] rd, erd; int lat; logic extra; bit hit, wb; int n, spurious;
    stall_cfg = 0; stall_left = 0; resp_delay = 10;
    log_we.delete(); log_addr.delete(); log_wdata.delete(); log_hold.delete();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h100; cpu_req_wdata = '0;
    n = 0;
    while (cpu_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cpu_req_valid = 1'b0; cpu_req_addr = '0;
    n = 0;
    while (log_we.size() == 0 && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (log_we.size() !== 1 || log_addr[0] !== 32'h100) begin
      n_fail++; $display("FAIL abort_refill_issued: got %0d ops want one read of 00000100", log_we.size());
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    n = 0; spurious = 0;
    do begin @(negedge clk); n++; if (cpu_resp_valid === 1'b1) spurious++; end
    while (cpu_req_ready !== 1'b1 && n < 100);
    n_cmp++; if (n !== 16) begin n_fail++; $display("FAIL abort_sweep_cycles: got %0d want 16", n); end
    n_cmp++; if (spurious !== 0) begin n_fail++; $display("FAIL abort_spurious_resp: got %0d want 0", spurious); end
    model_clear();
    resp_delay = 0;
    model_access(1'b0, 32'h100, '0, erd, hit, wb);
    cpu_access(1'b0, 32'h100, '0, rd, lat, extra);
    n_cmp++;
    if (log_we.size() !== 1 || log_we[0] !== 1'b0 || log_addr[0] !== 32'h100 || lat !== 4) begin
      n_fail++; $display("FAIL abort_then_miss: got ops=%0d lat=%0d want 1 read, lat 4", log_we.size(), lat);
    end
    n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL abort_then_rdata: got %h want %h", rd, erd); end
  endtask

  task automatic test_random();
    logic [25:0] tags[4];
    logic [31:0] a, wd, rd, erd; logic we, extra; int lat, elat, s, d, st0; bit hit, wb, ok;
    tags[0] = 26'h0; tags[1] = 26'h1; tags[2] = 26'h11; tags[3] = 26'h3FF_FFFF;
    st0 = stab_err;
    for (int k = 0; k < 120; k++) begin
      a  = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      s  = $urandom_range(0, 2); d = $urandom_range(0, 3);
      stall_cfg = s; stall_left = s; resp_delay = d;
      model_access(we, a, wd, erd, hit, wb);
      cpu_access(we, a, wd, rd, lat, extra);
      elat = hit ? 1 : (4 + s + d + (wb ? 1 + s : 0));
      n_cmp++; if (lat !== elat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, elat); end
      if (!we) begin
        n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", k, rd, erd); end
      end
      ok = (log_we.size() == e_we.size());
      if (ok) foreach (e_we[i])
        if (log_we[i] !== e_we[i] || log_addr[i] !== e_addr[i] || (e_we[i] && log_wdata[i] !== e_wdata[i])) ok = 0;
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rnd_mem_ops[%0d]: got %0d ops want %0d (addr %h)", k, log_we.size(), e_we.size(), a); end
      n_cmp++; if (extra !== 1'b0) begin n_fail++; $display("FAIL rnd_pulse_width[%0d]: got %b want 0", k, extra); end
    end
    n_cmp++; if (stab_err !== st0) begin n_fail++; $display("FAIL rnd_stability: got %0d changes want 0", stab_err - st0); end
    stall_cfg = 0; stall_left = 0; resp_delay = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit_wb();
    test_store_miss();
    test_wb_stall();
    test_reset_in_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache with one word per line.
- Sits between the core load/store unit and the memory bus.
- Successor to the single-cycle tag/data array block. Adds a valid/ready CPU handshake, miss handling, dirty-line writeback, a memory-side handshake and a hardware invalidate sweep after reset.
- Replaces the unconditional per-cycle lookup with a multi-cycle controller FSM.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: word and line width. Must be 32.
- INDEX_W, 11: index bits; the cache has 2^INDEX_W lines.
- Derived TAG_W = ADDR_W - INDEX_W - 2. Index is addr[INDEX_W+1:2]; tag is addr[ADDR_W-1:INDEX_W+2]; addr[1:0] is ignored.

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  synchronous, active-high
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  cache accepts request this cycle
- cpu_req_we  in  1  1=store, 0=load
- cpu_req_addr  in  ADDR_W  byte address
- cpu_req_wdata  in  DATA_W  store data
- cpu_resp_valid  out  1  one-cycle pulse: load data valid / store done
- cpu_resp_rdata  out  DATA_W  load data
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1=writeback, 0=refill read
- mem_req_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_req_wdata  out  DATA_W  writeback data
- mem_resp_valid  in  1  refill data valid (reads only)
- mem_resp_rdata  in  DATA_W  refill data

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Outputs during and immediately after reset:
  - cpu_req_ready=0, cpu_resp_valid=0, mem_req_valid=0, mem_req_we=0.
  - cpu_resp_rdata, mem_req_addr and mem_req_wdata are 0.
- States: INIT, IDLE, LOOKUP, WB, REFILL_REQ, REFILL_WAIT.
- INIT:
  - Entered on reset from any state. Any outstanding memory transaction is abandoned; mem_resp_valid is ignored outside REFILL_WAIT.
  - An INDEX_W-bit counter sweeps from 0 to 2^INDEX_W-1, clearing valid and dirty of one line per cycle.
  - After the last index, go to IDLE. First cpu_req_ready=1 is exactly 2^INDEX_W cycles after reset deasserts.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid, register we/addr/wdata and go to LOOKUP. The request is accepted in that cycle.
- LOOKUP (cpu_req_ready=0):
  - Hit = valid[idx] and tag[idx]==req_tag.
  - Load hit: cpu_resp_valid=1 with cpu_resp_rdata=data[idx] in this cycle, then IDLE. Hit latency is 1 cycle after acceptance.
  - Store hit: write data[idx], set dirty[idx]=1, cpu_resp_valid=1, then IDLE.
  - Miss with valid and dirty victim: go to WB. Otherwise go to REFILL_REQ.
- WB:
  - mem_req_valid=1, mem_req_we=1.
  - mem_req_addr = {victim tag, idx, 2'b00}; mem_req_wdata = data[idx].
  - Hold all of these stable until mem_req_ready. On the ready cycle, clear dirty[idx] and go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid=1, mem_req_we=0, mem_req_addr={req_tag, idx, 2'b00}.
  - Hold until mem_req_ready, then go to REFILL_WAIT.
- REFILL_WAIT:
  - mem_req_valid=0. Wait any number of cycles for mem_resp_valid.
  - On mem_resp_valid, write data[idx]=mem_resp_rdata, tag[idx]=req_tag, valid=1, dirty=0, then LOOKUP.
  - The replayed lookup hits, so the store merges there (write-allocate).
- Miss latency:
  - Clean miss with zero-wait memory: response 4 cycles after acceptance.
  - A writeback adds 1 cycle plus the ready stall.
- cpu_resp_valid is a single-cycle pulse and is never asserted outside LOOKUP.
- cpu_req_valid while cpu_req_ready=0 is ignored; the CPU holds it.
- At most one outstanding CPU request and one outstanding memory request.
- mem_req_valid is never withdrawn before mem_req_ready.
- Array reads are combinational from flop arrays; all writes happen on posedge.

Test Plan:
- INDEX_W=4, reset held 3 cycles then released -> cpu_req_ready stays 0 for 16 cycles, then 1; all valid bits 0.
- Load 0x0000_0040 on a cold cache, memory returns 0xDEADBEEF with zero wait -> one mem read at 0x40, cpu_resp_valid pulse 4 cycles after acceptance with rdata 0xDEADBEEF. Repeat the load -> hit, response 1 cycle after acceptance, no mem request.
- Store 0x1234_5678 to 0x40 (hit) -> dirty set, no mem traffic. Then load 0x0000_0440 (same index, INDEX_W=4):
  - mem write at 0x40 with data 0x12345678 first;
  - then mem read at 0x440;
  - then response with the refill data.
- Store miss to 0x80 with refill data 0xAAAA_AAAA and wdata 0x5555_5555 -> line holds 0x55555555 and is dirty; a subsequent load of 0x80 returns 0x55555555 with no mem traffic.
- mem_req_ready low for 5 cycles during WB -> mem_req_valid/we/addr/wdata stable for all 6 cycles; exactly one writeback is issued.
- Reset asserted in REFILL_WAIT -> INIT sweep runs, a late mem_resp_valid is ignored, and a subsequent load to the same address misses.
